fetch_unit: RTL and testbench

//  Instruction-fetch stage between the program counter register and the IF/ID boundary of the pipelined CPU.

---
 rtl/fetch_unit.sv | 137 +++++++++++++
 tb/tb_fetch_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: drives the PC register and fetches over a req/ack handshake into IF/ID.
// A single hold buffer keeps one fetched word while ID stalls; redirects squash in-flight fetches.
//
// state  | meaning
// IDLE   | first cycle after reset, no request outstanding
// REQ    | request asserted at pc_i, waiting for ack
// HOLD   | fetched word parked in the buffer until ID accepts it
module fetch_unit #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter logic [31:0] PC_INC    = 32'd4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] pc_i,
    output logic [31:0] pc_next_o,
    output logic        pc_write_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    input  logic        id_stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        ifid_valid_o,
    output logic [31:0] ifid_instr_o,
    output logic [31:0] ifid_pc4_o
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

    state_t      state_q, state_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc4_q, buf_pc4_d;
    logic [31:0] redir_q, redir_d;
    logic        redir_pend_q, redir_pend_d;
    logic [31:0] pc_inc;
    logic        slot_free;

    assign pc_inc       = pc_i + PC_INC;
    assign slot_free    = !ifid_valid_q || !id_stall_i;
    assign imem_addr_o  = pc_i;
    assign ifid_valid_o = ifid_valid_q;
    assign ifid_instr_o = ifid_valid_q ? ifid_instr_q : NOP_INSTR;
    assign ifid_pc4_o   = ifid_pc4_q;

    always_comb begin
        state_d      = state_q;
        ifid_valid_d = ifid_valid_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        buf_instr_d  = buf_instr_q;
        buf_pc4_d    = buf_pc4_q;
        redir_d      = redir_q;
        redir_pend_d = redir_pend_q;
        pc_next_o    = pc_inc;
        pc_write_o   = 1'b0;
        imem_req_o   = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                // State reads IDLE throughout reset; keep the PC write quiet then.
                if (redirect_i && !rst_i) begin
                    pc_write_o = 1'b1;
                    pc_next_o  = redirect_pc_i;
                end
            end
            S_REQ: begin
                imem_req_o = 1'b1;
                if (imem_ack_i) begin
                    pc_write_o = 1'b1;
                    if (redirect_i || redir_pend_q) begin
                        pc_next_o    = redirect_i ? redirect_pc_i : redir_q;
                        redir_pend_d = 1'b0;
                        if (slot_free) ifid_valid_d = 1'b0;
                    end else if (slot_free) begin
                        ifid_valid_d = 1'b1;
                        ifid_instr_d = imem_data_i;
                        ifid_pc4_d   = pc_inc;
                    end else begin
                        buf_instr_d = imem_data_i;
                        buf_pc4_d   = pc_inc;
                        state_d     = S_HOLD;
                    end
                end else begin
                    // PC is frozen until ack, so the target waits in redir_q.
                    if (redirect_i) begin
                        redir_d      = redirect_pc_i;
                        redir_pend_d = 1'b1;
                    end
                    if (slot_free) ifid_valid_d = 1'b0;
                end
            end
            S_HOLD: begin
                if (redirect_i) begin
                    pc_write_o = 1'b1;
                    pc_next_o  = redirect_pc_i;
                    state_d    = S_REQ;
                end else if (!id_stall_i) begin
                    ifid_valid_d = 1'b1;
                    ifid_instr_d = buf_instr_q;
                    ifid_pc4_d   = buf_pc4_q;
                    state_d      = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (redirect_i) ifid_valid_d = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc4_q   <= 32'h0;
            buf_instr_q  <= 32'h0;
            buf_pc4_q    <= 32'h0;
            redir_q      <= 32'h0;
            redir_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            buf_instr_q  <= buf_instr_d;
            buf_pc4_q    <= buf_pc4_d;
            redir_q      <= redir_d;
            redir_pend_q <= redir_pend_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a behavioural fetch model with an external PC register and a queue
// for the parked word, checked every cycle, plus directed scenarios with literal expectations.
module tb_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] pc_i;
    logic [31:0] pc_next_o;
    logic        pc_write_o;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_data_i = 32'h0;
    logic        id_stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        ifid_valid_o;
    logic [31:0] ifid_instr_o;
    logic [31:0] ifid_pc4_o;

    int checks = 0;
    int failures = 0;

    fetch_unit dut (
        .clk_i(clk_i), .rst_i(rst_i), .pc_i(pc_i),
        .pc_next_o(pc_next_o), .pc_write_o(pc_write_o),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i),
        .id_stall_i(id_stall_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .ifid_valid_o(ifid_valid_o), .ifid_instr_o(ifid_instr_o), .ifid_pc4_o(ifid_pc4_o)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } ent_t;

    logic [31:0] m_pc = 32'h0;      // the PC register the DUT steers
    bit          m_started = 1'b0;  // first post-reset cycle has elapsed
    bit          m_valid = 1'b0;
    logic [31:0] m_instr = 32'h0;
    logic [31:0] m_pc4 = 32'h0;
    bit          m_pend = 1'b0;
    logic [31:0] m_ptgt = 32'h0;
    ent_t        hold_q[$];
    ent_t        m_ent;
    bit          m_drain;
    logic [31:0] m_seq;

    assign pc_i = m_pc;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_pc = 32'h0; m_started = 1'b0; m_valid = 1'b0; m_instr = 32'h0;
            m_pc4 = 32'h0; m_pend = 1'b0; m_ptgt = 32'h0; hold_q.delete();
        end else begin
            m_drain = !m_valid || !id_stall_i;
            m_seq   = m_pc + 32'd4;
            if (!m_started) begin
                m_started = 1'b1;
                if (redirect_i) m_pc = redirect_pc_i;
            end else if (hold_q.size() != 0) begin
                if (redirect_i) begin
                    hold_q.delete();
                    m_pc = redirect_pc_i;
                end else if (!id_stall_i) begin
                    m_ent = hold_q.pop_front();
                    m_valid = 1'b1; m_instr = m_ent.instr; m_pc4 = m_ent.pc4;
                end
            end else if (imem_ack_i) begin
                if (redirect_i || m_pend) begin
                    m_pc = redirect_i ? redirect_pc_i : m_ptgt;
                    if (m_drain) m_valid = 1'b0;
                end else begin
                    if (m_drain) begin
                        m_valid = 1'b1; m_instr = imem_data_i; m_pc4 = m_seq;
                    end else begin
                        hold_q.push_back('{instr: imem_data_i, pc4: m_seq});
                    end
                    m_pc = m_seq;
                end
                m_pend = 1'b0;
            end else begin
                if (redirect_i) begin
                    m_pend = 1'b1; m_ptgt = redirect_pc_i;
                end
                if (m_drain) m_valid = 1'b0;
            end
            if (redirect_i) m_valid = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    bit          e_req, e_wr;
    logic [31:0] e_next;
    always @(negedge clk_i) begin
        e_req = m_started && (hold_q.size() == 0);
        if (!m_started)              e_wr = redirect_i && !rst_i;
        else if (hold_q.size() != 0) e_wr = redirect_i;
        else                         e_wr = imem_ack_i;
        if (redirect_i)                          e_next = redirect_pc_i;
        else if (e_req && imem_ack_i && m_pend)  e_next = m_ptgt;
        else                                     e_next = m_pc + 32'd4;
        chk("m_req", {31'b0, imem_req_o}, {31'b0, e_req});
        chk("m_pc_write", {31'b0, pc_write_o}, {31'b0, e_wr});
        if (e_wr || !redirect_i) chk("m_pc_next", pc_next_o, e_next);
        if (e_req) chk("m_addr", imem_addr_o, m_pc);
        chk("m_valid", {31'b0, ifid_valid_o}, {31'b0, m_valid});
        chk("m_instr", ifid_instr_o, m_valid ? m_instr : 32'h0);
        if (m_valid || rst_i) chk("m_pc4", ifid_pc4_o, m_pc4);
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input bit ack, input bit stall, input bit redir, input logic [31:0] rpc);
        imem_ack_i    = ack;
        imem_data_i   = mem(m_pc);
        id_stall_i    = stall;
        redirect_i    = redir;
        redirect_pc_i = rpc;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #1 rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_req", {31'b0, imem_req_o}, 32'd0);
        chk("rst_wr", {31'b0, pc_write_o}, 32'd0);
        chk("rst_valid", {31'b0, ifid_valid_o}, 32'd0);
        chk("rst_instr", ifid_instr_o, 32'h0);
        chk("rst_pc4", ifid_pc4_o, 32'h0);
        rst_i = 1'b0;
        drive(0, 0, 0, 0);
        #1 chk("idle_req", {31'b0, imem_req_o}, 32'd0);
        tick();

        // zero-wait fetch at 0,4,8
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0);
            #1;
            chk("zw_req", {31'b0, imem_req_o}, 32'd1);
            chk("zw_addr", imem_addr_o, 32'(4 * i));
            chk("zw_wr", {31'b0, pc_write_o}, 32'd1);
            chk("zw_next", pc_next_o, 32'(4 * i + 4));
            tick();
            chk("zw_valid", {31'b0, ifid_valid_o}, 32'd1);
            chk("zw_instr", ifid_instr_o, 32'hC0DE_0000 + 32'(4 * i));
            chk("zw_pc4", ifid_pc4_o, 32'(4 * i + 4));
        end

        // ack after 3 cycles at pc 12
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0);
            #1;
            chk("dly_addr", imem_addr_o, 32'h0000_000C);
            chk("dly_wr", {31'b0, pc_write_o}, 32'd0);
            tick();
            chk("dly_bubble", {31'b0, ifid_valid_o}, 32'd0);
        end
        drive(1, 0, 0, 0);
        #1 chk("dly_ack_wr", {31'b0, pc_write_o}, 32'd1);
        tick();
        chk("dly_instr", ifid_instr_o, 32'hC0DE_000C);
        chk("dly_pc4", ifid_pc4_o, 32'h0000_0010);

        // stall 4 cycles, ack in the first
        drive(1, 1, 0, 0);
        tick();
        chk("stl_keep", ifid_instr_o, 32'hC0DE_000C);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0);
            #1 chk("stl_hold_req", {31'b0, imem_req_o}, 32'd0);
            tick();
            chk("stl_keep2", ifid_instr_o, 32'hC0DE_000C);
        end
        drive(0, 0, 0, 0);
        #1 chk("stl_rel_req", {31'b0, imem_req_o}, 32'd0);
        tick();
        chk("stl_buf_instr", ifid_instr_o, 32'hC0DE_0010);
        chk("stl_buf_pc4", ifid_pc4_o, 32'h0000_0014);

        // redirect one cycle before a delayed ack
        drive(0, 0, 1, 32'h100);
        #1 chk("rd_wr", {31'b0, pc_write_o}, 32'd0);
        tick();
        chk("rd_valid", {31'b0, ifid_valid_o}, 32'd0);
        drive(1, 0, 0, 0);
        #1 chk("rd_next", pc_next_o, 32'h0000_0100);
        tick();
        chk("rd_discard", {31'b0, ifid_valid_o}, 32'd0);
        drive(1, 0, 0, 0);
        #1 chk("rd_addr", imem_addr_o, 32'h0000_0100);
        tick();
        chk("rd_instr", ifid_instr_o, 32'hC0DE_0100);
        chk("rd_pc4", ifid_pc4_o, 32'h0000_0104);

        // redirect while holding under stall
        drive(1, 1, 0, 0);
        tick();
        drive(0, 1, 1, 32'h200);
        #1;
        chk("hr_wr", {31'b0, pc_write_o}, 32'd1);
        chk("hr_next", pc_next_o, 32'h0000_0200);
        tick();
        chk("hr_valid", {31'b0, ifid_valid_o}, 32'd0);
        chk("hr_nop", ifid_instr_o, 32'h0);
        drive(0, 1, 0, 0);
        #1;
        chk("hr_req", {31'b0, imem_req_o}, 32'd1);
        chk("hr_addr", imem_addr_o, 32'h0000_0200);
        tick();

        // redirect coincident with ack, then PC wrap at the top of memory
        drive(1, 0, 1, 32'hFFFF_FFFC);
        #1 chk("wr_redir_next", pc_next_o, 32'hFFFF_FFFC);
        tick();
        chk("wr_discard", {31'b0, ifid_valid_o}, 32'd0);
        drive(1, 0, 0, 0);
        #1 chk("wrap_next", pc_next_o, 32'h0);
        tick();
        chk("wrap_instr", ifid_instr_o, 32'h3F21_FFFC);
        chk("wrap_pc4", ifid_pc4_o, 32'h0);

        // reset mid-request with an ack arriving during reset
        drive(0, 0, 0, 0);
        #2 rst_i = 1'b1;
        #1;
        chk("mrst_req", {31'b0, imem_req_o}, 32'd0);
        chk("mrst_valid", {31'b0, ifid_valid_o}, 32'd0);
        drive(1, 0, 0, 0);
        tick();
        tick();
        chk("mrst_wr", {31'b0, pc_write_o}, 32'd0);
        chk("mrst_instr", ifid_instr_o, 32'h0);
        rst_i = 1'b0;
        drive(0, 0, 0, 0);
        #1 chk("mrst_idle_req", {31'b0, imem_req_o}, 32'd0);
        tick();
        chk("mrst_resume_req", {31'b0, imem_req_o}, 32'd1);
        chk("mrst_resume_addr", imem_addr_o, 32'h0);

        // redirect in the idle cycle after reset
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        drive(0, 0, 1, 32'h40);
        #1;
        chk("idle_rd_wr", {31'b0, pc_write_o}, 32'd1);
        chk("idle_rd_next", pc_next_o, 32'h0000_0040);
        tick();
        drive(0, 0, 0, 0);
        #1 chk("idle_rd_addr", imem_addr_o, 32'h0000_0040);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
